// File: rtl/vdp_ssg_param.sv
// rtl/vdp_ssg_param.sv - parametrised VDP sync generator (line interrupt under VDP_SSG_HINT_EN)
module vdp_ssg_param #(
    parameter int H_TOTAL      = 1368,
    parameter int HSYNC_LEN    = 100,
    parameter int HACT_START   = 232,
    parameter int H_ACTIVE     = 1024,
    parameter int V_TOTAL_NTSC = 262,
    parameter int V_TOTAL_PAL  = 313,
    parameter int VSYNC_LINES  = 3,
    parameter int VACT_START   = 24,
    parameter int V_ACTIVE     = 192
) (
    input  logic        clk21m,
    input  logic        reset,
    input  logic        reg_pal_mode,
    input  logic        reg_interlace_mode,
    input  logic [3:0]  reg_adj_x,
    input  logic [7:0]  reg_hint_line,
    input  logic        hint_ack,
    output logic [10:0] h_cnt,
    output logic [9:0]  v_cnt,
    output logic [1:0]  dotstate,
    output logic [2:0]  eightdotstate,
    output logic        field,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        window_x,
    output logic        window_y,
    output logic        vblank_start,
    output logic        hint_pending
);

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST_N  = 10'(V_TOTAL_NTSC - 1);
    localparam logic [9:0]  V_LAST_P  = 10'(V_TOTAL_PAL - 1);
    localparam logic [9:0]  VACT_END  = 10'(VACT_START + V_ACTIVE);

    logic        pal_sh;
    logic        ilace_sh;
    logic [3:0]  adj_q;

    logic        h_wrap;
    logic        v_wrap;
    logic [10:0] h_nxt;
    logic [9:0]  v_nxt;
    logic [9:0]  v_last;
    logic [3:0]  adj_line;
    logic [11:0] h_ext;
    logic [11:0] xs;
    logic [11:0] xe;
    logic        wy_nxt;

    always_comb begin
        h_wrap   = (h_cnt == H_LAST);
        h_nxt    = h_wrap ? 11'd0 : h_cnt + 11'd1;
        // Odd interlaced field carries the extra half-frame line.
        v_last   = (pal_sh ? V_LAST_P : V_LAST_N) + {9'd0, ilace_sh & field};
        v_wrap   = h_wrap && (v_cnt == v_last);
        v_nxt    = v_wrap ? 10'd0 : (h_wrap ? v_cnt + 10'd1 : v_cnt);
        // Adjust is live during h_cnt==0 and frozen for the rest of the line.
        adj_line = (h_cnt == 11'd0) ? reg_adj_x : adj_q;
        // Two's-complement sum; parameter limits keep it non-negative.
        xs       = 12'(HACT_START) + {{6{adj_line[3]}}, adj_line, 2'b00};
        xe       = xs + 12'(H_ACTIVE);
        h_ext    = {1'b0, h_nxt};
        wy_nxt   = (v_nxt >= 10'(VACT_START)) && (v_nxt < VACT_END);
    end

    always_ff @(posedge clk21m) begin
        if (reset) begin
            h_cnt         <= 11'd0;
            v_cnt         <= 10'd0;
            dotstate      <= 2'd0;
            eightdotstate <= 3'd0;
            field         <= 1'b0;
            hsync_n       <= 1'b0;
            vsync_n       <= 1'b0;
            window_x      <= 1'b0;
            window_y      <= 1'b0;
            vblank_start  <= 1'b0;
            pal_sh        <= 1'b0;
            ilace_sh      <= 1'b0;
            adj_q         <= 4'd0;
        end else begin
            h_cnt         <= h_nxt;
            v_cnt         <= v_nxt;
            dotstate      <= h_nxt[1:0];
            eightdotstate <= h_nxt[4:2];
            if (h_cnt == 11'd0) begin
                adj_q <= reg_adj_x;
            end
            if (v_wrap) begin
                field <= ilace_sh ? ~field : 1'b0;
                // An interlaced frame is only complete after field 1.
                if (!ilace_sh || field) begin
                    pal_sh   <= reg_pal_mode;
                    ilace_sh <= reg_interlace_mode;
                end
            end
            hsync_n      <= (h_nxt >= 11'(HSYNC_LEN));
            vsync_n      <= (v_nxt >= 10'(VSYNC_LINES));
            window_x     <= (h_ext >= xs) && (h_ext < xe);
            window_y     <= wy_nxt;
            vblank_start <= (h_nxt == 11'd0) && (v_nxt == VACT_END);
        end
    end

`ifdef VDP_SSG_HINT_EN
    logic [9:0] v_rel;
    logic       hint_set;

    always_comb begin
        v_rel    = v_nxt - 10'(VACT_START);
        hint_set = (h_ext == xe) && wy_nxt && (v_rel[7:0] == reg_hint_line);
    end

    always_ff @(posedge clk21m) begin
        if (reset) begin
            hint_pending <= 1'b0;
        end else if (hint_set) begin
            hint_pending <= 1'b1;
        end else if (hint_ack) begin
            hint_pending <= 1'b0;
        end
    end
`else
    logic unused_hint;
    assign unused_hint  = ^{hint_ack, reg_hint_line};
    assign hint_pending = 1'b0;
`endif

endmodule
